// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL in reset at power-up, waits for lock
// with a timeout and bounded retries, qualifies lock stability and only then
// releases the system reset. Loss of lock in RUN re-sequences the PLL.
// Runs entirely on the PLL reference clock.
module pll_reset_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       run,
   output logic       fail,
   output logic [2:0] state,
   output logic [3:0] retries,
   output logic [7:0] lock_loss_cnt
);

   // One counter serves every timed state, so it is sized for the longest one.
   localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t           cur_state;
   state_t           nxt_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [3:0]       retries_nxt;
   logic [7:0]       loss_nxt;
   logic             lock_meta;
   logic             lock_s;

   // Two-flop synchronizer bringing the asynchronous lock indicator into refclk.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   // Next-state, counter and bookkeeping decisions; restart overrides everything.
   always_comb begin
      nxt_state   = cur_state;
      retries_nxt = retries;
      loss_nxt    = lock_loss_cnt;
      cnt_nxt     = '0;

      case (cur_state)
         S_RESET_PLL: begin
            if (cnt == RST_LAST) nxt_state = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (lock_s) begin
               nxt_state = S_STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               if (retries == RETRY_LIMIT) begin
                  nxt_state = S_FAIL;
               end else begin
                  nxt_state   = S_RESET_PLL;
                  retries_nxt = retries + 4'd1;
               end
            end
         end
         S_STABLE: begin
            // A lock drop here restarts the wait but does not consume a retry.
            if (!lock_s) begin
               nxt_state = S_WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
               nxt_state   = S_RUN;
               retries_nxt = 4'd0;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               nxt_state   = S_RESET_PLL;
               retries_nxt = 4'd0;
               if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
            end
         end
         S_FAIL: begin
            nxt_state = S_FAIL;
         end
         default: begin
            nxt_state = S_RESET_PLL;
         end
      endcase

      if (restart) begin
         nxt_state   = S_RESET_PLL;
         retries_nxt = 4'd0;
         loss_nxt    = lock_loss_cnt;
      end

      // The counter restarts on every state change and is idle in RUN and FAIL.
      if (restart || (nxt_state != cur_state) || (cur_state == S_RUN) ||
          (cur_state == S_FAIL)) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // State register; outputs are registered from the next-state decode so they
   // change on the same edge as the state and never glitch.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state     <= S_RESET_PLL;
         cnt           <= '0;
         retries       <= 4'd0;
         lock_loss_cnt <= 8'd0;
         pll_rst       <= 1'b1;
         sys_rst_n     <= 1'b0;
         run           <= 1'b0;
         fail          <= 1'b0;
      end else begin
         cur_state     <= nxt_state;
         cnt           <= cnt_nxt;
         retries       <= retries_nxt;
         lock_loss_cnt <= loss_nxt;
         pll_rst       <= (nxt_state == S_RESET_PLL) || (nxt_state == S_FAIL);
         sys_rst_n     <= (nxt_state == S_RUN);
         run           <= (nxt_state == S_RUN);
         fail          <= (nxt_state == S_FAIL);
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: scenario tasks with a cycle-level
// reference model derived from the sequencing rules.
module tb_pll_reset_sequencer;

   localparam int RST_CYCLES    = 16;
   localparam int LOCK_TIMEOUT  = 64;
   localparam int STABLE_CYCLES = 32;
   localparam int MAX_RETRY     = 3;

   // {pll_rst, sys_rst_n, run, fail, state, retries, lock_loss_cnt}
   localparam logic [18:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0};

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       run;
   logic       fail;
   logic [2:0] state;
   logic [3:0] retries;
   logic [7:0] lock_loss_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 refclk = ~refclk;

   pll_reset_sequencer #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRY    (MAX_RETRY)
   ) dut (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .restart      (restart),
      .pll_rst      (pll_rst),
      .sys_rst_n    (sys_rst_n),
      .run          (run),
      .fail         (fail),
      .state        (state),
      .retries      (retries),
      .lock_loss_cnt(lock_loss_cnt)
   );

   // Reference model: phase (0 reset-pll, 1 wait, 2 stable, 3 run, 4 fail),
   // cycles spent in the phase, and the lock input as seen two edges late.
   int ph;
   int t;
   int m_retries;
   int m_loss;
   bit seen1;
   bit seen2;

   task automatic model_reset();
      ph = 0; t = 0; m_retries = 0; m_loss = 0; seen1 = 0; seen2 = 0;
   endtask

   task automatic model_edge();
      bit ls;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ls    = seen2;
      seen2 = seen1;
      seen1 = pll_locked;
      if (restart) begin
         ph = 0; t = 0; m_retries = 0;
         return;
      end
      t++;
      case (ph)
         0: if (t == RST_CYCLES) begin ph = 1; t = 0; end
         1: begin
            if (ls) begin
               ph = 2; t = 0;
            end else if (t == LOCK_TIMEOUT) begin
               if (m_retries == MAX_RETRY) begin
                  ph = 4; t = 0;
               end else begin
                  m_retries++; ph = 0; t = 0;
               end
            end
         end
         2: begin
            if (!ls) begin
               ph = 1; t = 0;
            end else if (t == STABLE_CYCLES) begin
               m_retries = 0; ph = 3; t = 0;
            end
         end
         3: begin
            if (!ls) begin
               if (m_loss < 255) m_loss++;
               m_retries = 0; ph = 0; t = 0;
            end
         end
         default: ;
      endcase
   endtask

   function automatic logic [18:0] exp_vec();
      return {(ph == 0) || (ph == 4), ph == 3, ph == 3, ph == 4,
              3'(ph), 4'(m_retries), 8'(m_loss)};
   endfunction

   function automatic logic [18:0] obs();
      return {pll_rst, sys_rst_n, run, fail, state, retries, lock_loss_cnt};
   endfunction

   task automatic tick();
      @(posedge refclk);
      model_edge();
      @(negedge refclk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
      model_reset();
      repeat (3) tick();
      n_cmp++;
      if (obs() !== RESET_VEC) begin
         n_bad++;
         $display("FAIL reset_values got=%h exp=%h", obs(), RESET_VEC);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_power_up();
      int fall_at = -1;
      int lock_edge = -1;
      int stable_at = -1;
      int run_at = -1;
      int delay = $urandom_range(5, 50);
      for (int c = 1; c <= 1000 && run_at < 0; c++) begin
         tick();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL powerup_c%0d got=%h exp=%h", c, obs(), exp_vec());
         end
         if (!pll_rst && fall_at < 0) fall_at = c;
         if (fall_at >= 0 && lock_edge < 0 && c == fall_at + delay) begin
            pll_locked = 1'b1;
            lock_edge = c + 1;
         end
         if (state == 3'd2 && stable_at < 0) stable_at = c;
         if (state == 3'd3) run_at = c;
      end
      n_cmp++;
      if (fall_at !== RST_CYCLES) begin
         n_bad++;
         $display("FAIL powerup_pll_rst_len got=%0d exp=%0d", fall_at, RST_CYCLES);
      end
      n_cmp++;
      if (lock_edge < 0 || stable_at !== lock_edge + 2) begin
         n_bad++;
         $display("FAIL powerup_stable_entry got=%0d exp=%0d", stable_at, lock_edge + 2);
      end
      n_cmp++;
      if (stable_at < 0 || run_at !== stable_at + STABLE_CYCLES) begin
         n_bad++;
         $display("FAIL powerup_run_entry got=%0d exp=%0d", run_at, stable_at + STABLE_CYCLES);
      end
      n_cmp++;
      if (sys_rst_n !== 1'b1 || retries !== 4'd0) begin
         n_bad++;
         $display("FAIL powerup_run_outputs sys_rst_n=%b retries=%0d exp 1/0", sys_rst_n, retries);
      end
   endtask

   task automatic test_timeout_fail();
      int rise_r[4];
      int lens[5];
      int n_rise = 0;
      int n_fall = 0;
      int hi = 1;
      bit prev = 1'b1;
      bit fail_seen = 1'b0;
      int extra = 0;
      pll_locked = 1'b0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_bad++;
         $display("FAIL timeout_restart got=%h exp=%h", obs(), exp_vec());
      end
      for (int c = 1; c <= 1500 && extra < 20; c++) begin
         tick();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL timeout_c%0d got=%h exp=%h", c, obs(), exp_vec());
         end
         if (pll_rst && !prev) begin
            if (n_rise < 4) rise_r[n_rise] = int'(retries);
            n_rise++;
         end
         if (!pll_rst && prev) begin
            if (n_fall < 5) lens[n_fall] = hi;
            n_fall++;
            hi = 0;
         end
         if (pll_rst) hi++;
         prev = pll_rst;
         if (fail) fail_seen = 1'b1;
         if (fail_seen) begin
            extra++;
            n_cmp++;
            if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || state !== 3'd4) begin
               n_bad++;
               $display("FAIL fail_hold pll_rst=%b sys_rst_n=%b state=%0d exp 1/0/4",
                        pll_rst, sys_rst_n, state);
            end
         end
      end
      n_cmp++;
      if (!fail_seen || n_rise !== 4 || n_fall !== 4) begin
         n_bad++;
         $display("FAIL timeout_pulses fail=%b rises=%0d falls=%0d exp 1/4/4",
                  fail_seen, n_rise, n_fall);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (lens[i] !== RST_CYCLES) begin
               n_bad++;
               $display("FAIL timeout_pulse%0d_len got=%0d exp=%0d", i, lens[i], RST_CYCLES);
            end
            n_cmp++;
            if (rise_r[i] !== ((i < 3) ? i + 1 : 3)) begin
               n_bad++;
               $display("FAIL timeout_retry%0d got=%0d exp=%0d", i, rise_r[i],
                        (i < 3) ? i + 1 : 3);
            end
         end
      end
   endtask

   task automatic test_restart_from_fail();
      int hi = 1;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      n_cmp++;
      if (fail !== 1'b0 || retries !== 4'd0 || state !== 3'd0 || pll_rst !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_exit fail=%b retries=%0d state=%0d pll_rst=%b exp 0/0/0/1",
                  fail, retries, state, pll_rst);
      end
      for (int c = 1; c <= 100 && pll_rst; c++) begin
         tick();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL restart_c%0d got=%h exp=%h", c, obs(), exp_vec());
         end
         if (pll_rst) hi++;
      end
      n_cmp++;
      if (hi !== RST_CYCLES) begin
         n_bad++;
         $display("FAIL restart_pulse_len got=%0d exp=%0d", hi, RST_CYCLES);
      end
   endtask

   task automatic test_glitch();
      int k = $urandom_range(4, STABLE_CYCLES / 2);
      int g = $urandom_range(1, 5);
      bit reached = 1'b0;
      bit saw_wait = 1'b0;
      int restable = -1;
      int run_at = -1;
      pll_locked = 1'b1;
      for (int c = 1; c <= 200 && !reached; c++) begin
         tick();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL glitch_pre_c%0d got=%h exp=%h", c, obs(), exp_vec());
         end
         if (state == 3'd2) reached = 1'b1;
      end
      repeat (k) tick();
      pll_locked = 1'b0;
      repeat (g) tick();
      pll_locked = 1'b1;
      for (int c = 1; c <= 300 && run_at < 0; c++) begin
         tick();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL glitch_c%0d got=%h exp=%h", c, obs(), exp_vec());
         end
         if (state == 3'd1) saw_wait = 1'b1;
         if (saw_wait && state == 3'd2 && restable < 0) restable = c;
         if (state == 3'd3) run_at = c;
      end
      n_cmp++;
      if (!reached || !saw_wait || restable < 0 || run_at !== restable + STABLE_CYCLES) begin
         n_bad++;
         $display("FAIL glitch_requalify stable=%b wait=%b restable=%0d run=%0d exp run=restable+%0d",
                  reached, saw_wait, restable, run_at, STABLE_CYCLES);
      end
      n_cmp++;
      if (retries !== 4'd0) begin
         n_bad++;
         $display("FAIL glitch_retries got=%0d exp=0", retries);
      end
   endtask

   task automatic test_lock_loss();
      for (int i = 0; i < 300; i++) begin
         int edges = 0;
         bit low = 1'b0;
         bit in_run = 1'b0;
         int exp_loss = (i + 1 > 255) ? 255 : i + 1;
         pll_locked = 1'b0;
         for (int c = 1; c <= 3 && !low; c++) begin
            tick();
            edges = c;
            if (!sys_rst_n) low = 1'b1;
         end
         n_cmp++;
         if (!low || state !== 3'd0 || int'(lock_loss_cnt) !== exp_loss) begin
            n_bad++;
            $display("FAIL lockloss_%0d low=%b edges=%0d state=%0d cnt=%0d exp 1/<=3/0/%0d",
                     i, low, edges, state, lock_loss_cnt, exp_loss);
         end
         repeat ($urandom_range(0, 20)) tick();
         pll_locked = 1'b1;
         for (int c = 1; c <= 300 && !in_run; c++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_vec()) begin
               n_bad++;
               $display("FAIL lockloss_%0d_c%0d got=%h exp=%h", i, c, obs(), exp_vec());
            end
            if (state == 3'd3) in_run = 1'b1;
         end
      end
      n_cmp++;
      if (lock_loss_cnt !== 8'd255 || run !== 1'b1) begin
         n_bad++;
         $display("FAIL lockloss_saturate cnt=%0d run=%b exp 255/1", lock_loss_cnt, run);
      end
   endtask

   task automatic test_async_reset();
      bit reached = 1'b0;
      int fall_at = -1;
      int run_at = -1;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      for (int c = 1; c <= 100 && !reached; c++) begin
         tick();
         if (state == 3'd2) reached = 1'b1;
      end
      repeat ($urandom_range(1, STABLE_CYCLES - 4)) tick();
      n_cmp++;
      if (state !== 3'd2) begin
         n_bad++;
         $display("FAIL async_pre_state got=%0d exp=2", state);
      end
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (obs() !== RESET_VEC) begin
         n_bad++;
         $display("FAIL async_immediate got=%h exp=%h", obs(), RESET_VEC);
      end
      @(negedge refclk);
      repeat (2) tick();
      n_cmp++;
      if (obs() !== RESET_VEC) begin
         n_bad++;
         $display("FAIL async_held got=%h exp=%h", obs(), RESET_VEC);
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 300 && run_at < 0; c++) begin
         tick();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL async_c%0d got=%h exp=%h", c, obs(), exp_vec());
         end
         if (!pll_rst && fall_at < 0) fall_at = c;
         if (state == 3'd3) run_at = c;
      end
      n_cmp++;
      if (fall_at !== RST_CYCLES || run_at < 0 || lock_loss_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL async_resequence fall=%0d run=%0d cnt=%0d exp %0d/>0/0",
                  fall_at, run_at, lock_loss_cnt, RST_CYCLES);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      for (int c = 1; c <= 3000; c++) begin
         if (hold == 0) begin
            pll_locked = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 120);
         end
         hold--;
         restart = ($urandom_range(0, 99) == 0);
         tick();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random_c%0d got=%h exp=%h", c, obs(), exp_vec());
         end
      end
      restart = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_timeout_fail();
      test_restart_from_fail();
      test_glitch();
      test_lock_loss();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
